// File: rtl/hls_deadlock_pkg.sv
// Shared definitions for the HLS dataflow deadlock monitors: FSM state
// encoding, the counter sizing helper and default parameter values.
package hls_deadlock_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WATCH    = 2'd1,
        DETECTED = 2'd2
    } state_t;

    localparam int DEFAULT_THRESH = 16;
    localparam int DEFAULT_EVT_W  = 16;

    // Number of bits needed to encode values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hls_deadlock_sat_counter.sv
// Generic saturating up-counter with a synchronous clear that takes
// priority over increment. Holds at all ones instead of wrapping.
module hls_deadlock_sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count register: clear wins, increment stops at the all-ones value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/hls_deadlock_multi_monitor.sv
// Deadlock monitor for one HLS dataflow region. A stall condition built from
// the AXIS channels and the sub-instances must persist for THRESH consecutive
// cycles before `block` asserts; `block` can feed a parent monitor's
// inst_block_sigs so regions chain hierarchically.
module hls_deadlock_multi_monitor
    import hls_deadlock_pkg::*;
#(
    parameter int NUM_AXIS = 2,
    parameter int NUM_INST = 1,
    parameter int THRESH   = DEFAULT_THRESH,
    parameter int STICKY   = 0,
    parameter int EVT_W    = DEFAULT_EVT_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         clear,
    input  logic [NUM_AXIS-1:0]          axis_block_sigs,
    input  logic [NUM_INST-1:0]          inst_idle_sigs,
    input  logic [NUM_INST-1:0]          inst_block_sigs,
    output logic                         block,
    output logic                         block_pending,
    output logic [NUM_AXIS+NUM_INST-1:0] block_src,
    output logic [EVT_W-1:0]             event_cnt
);

    localparam int CW = clog2(THRESH + 1);
    localparam int SW = NUM_AXIS + NUM_INST;

    logic          inst_cond;
    logic          raw;
    logic [SW-1:0] src_vec;
    state_t        state;
    state_t        next_state;
    logic [CW-1:0] persist_cnt;
    logic [31:0]   persist_next_val;
    logic          persist_inc;
    logic          persist_clr;
    logic          evt_inc;

    // Sub-instances count as deadlocked only when none is still working and
    // at least one is actually blocked (all-idle is a finished region).
    assign inst_cond = (&(inst_block_sigs | inst_idle_sigs)) & (|inst_block_sigs);
    assign raw       = (|axis_block_sigs) | inst_cond;
    assign src_vec   = {inst_block_sigs & {NUM_INST{inst_cond}}, axis_block_sigs};

    assign persist_next_val = 32'(persist_cnt) + 32'd1;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: clear overrides everything, WATCH requires an
    // unbroken run of raw with enable, DETECTED exits on raw=0 unless sticky.
    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && raw) begin
                        if (THRESH == 1) begin
                            next_state = DETECTED;
                        end else begin
                            next_state = WATCH;
                        end
                    end
                end
                WATCH: begin
                    if (!enable || !raw) begin
                        next_state = IDLE;
                    end else if (persist_next_val == 32'(THRESH)) begin
                        next_state = DETECTED;
                    end
                end
                DETECTED: begin
                    if ((STICKY == 0) && !raw) begin
                        next_state = IDLE;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // The persistence count is only meaningful while watching; any other
    // destination state zeroes it so the next run starts fresh.
    always_comb begin
        persist_inc = (next_state == WATCH);
        persist_clr = (next_state != WATCH);
        evt_inc     = (state != DETECTED) && (next_state == DETECTED);
    end

    hls_deadlock_sat_counter #(
        .W(CW)
    ) u_persist_cnt (
        .clock(clock),
        .reset(reset),
        .clr  (persist_clr),
        .inc  (persist_inc),
        .cnt  (persist_cnt)
    );

    hls_deadlock_sat_counter #(
        .W(EVT_W)
    ) u_event_cnt (
        .clock(clock),
        .reset(reset),
        .clr  (clear),
        .inc  (evt_inc),
        .cnt  (event_cnt)
    );

    // Source snapshot taken on entry to DETECTED and kept afterwards so the
    // culprit stays visible even after a non-sticky detection has ended.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            block_src <= '0;
        end else if (clear) begin
            block_src <= '0;
        end else if (evt_inc) begin
            block_src <= src_vec;
        end
    end

    assign block         = (state == DETECTED);
    assign block_pending = (state == WATCH);

endmodule
